// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the pipelined MIPS core: drives the write-enable and
// flush-to-NOP controls of the PC, IF/ID, ID/EX and EX/MEM registers.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; handles branch flush, MDU start, load-use bubble
// MDU_WAIT | holding the pipeline until the multiply/divide completes
module pipeline_hazard_ctrl #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        areset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_reg_write,
   input  logic        branch_taken,
   input  logic        mdu_start,
   input  logic        mdu_div,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        ifid_flush,
   output logic        idex_we,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [15:0] stall_count
);

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   // The start cycle is one of the N stall cycles, and the last wait cycle is
   // the one where the counter reads zero, hence N-2.
   localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 2);
   localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 2);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       load_use;

   assign load_use = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q     <= RUN;
         cnt_q       <= 8'd0;
         stall_count <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (!pc_we && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mdu_busy    = 1'b0;
      mdu_done    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (branch_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (mdu_start) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_we     = 1'b0;
               exmem_flush = 1'b1;
               mdu_busy    = 1'b1;
               state_d     = MDU_WAIT;
               cnt_d       = mdu_div ? DIV_LOAD : MULT_LOAD;
            end else if (load_use) begin
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
            end
         end
         MDU_WAIT: begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            mdu_busy    = 1'b1;
            if (cnt_q == 8'd0) begin
               mdu_done = 1'b1;
               state_d  = RUN;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, branch priority,
// multiply/divide stalls, reset abort and stall_count saturation.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        areset;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
   logic        branch_taken, mdu_start, mdu_div;
   logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush;
   logic        mdu_busy, mdu_done;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_sc;
   int wait_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
      .clk          (clk),
      .areset       (areset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_reg_write (ex_reg_write),
      .branch_taken (branch_taken),
      .mdu_start    (mdu_start),
      .mdu_div      (mdu_div),
      .pc_we        (pc_we),
      .ifid_we      (ifid_we),
      .ifid_flush   (ifid_flush),
      .idex_we      (idex_we),
      .idex_flush   (idex_flush),
      .exmem_flush  (exmem_flush),
      .mdu_busy     (mdu_busy),
      .mdu_done     (mdu_done),
      .stall_count  (stall_count)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_reg_write = 1'b0;
      branch_taken = 1'b0; mdu_start = 1'b0; mdu_div = 1'b0;
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, mdu_busy, mdu_done}
   function automatic logic [15:0] ctl();
      return {8'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, mdu_busy, mdu_done};
   endfunction

   localparam logic [15:0] CTL_IDLE  = 16'b1101_0000;
   localparam logic [15:0] CTL_LU    = 16'b0001_1000;
   localparam logic [15:0] CTL_BR    = 16'b1111_1000;
   localparam logic [15:0] CTL_MDU   = 16'b0000_0110;
   localparam logic [15:0] CTL_MDUD  = 16'b0000_0111;

   initial begin
      idle();
      areset = 1'b0;
      #3;
      chk("por_ctl", ctl(), CTL_IDLE);
      chk("por_sc", stall_count, 16'd0);
      tick();
      areset = 1'b1;
      tick(); tick();
      // mid-cycle reset assertion
      #2 areset = 1'b0;
      #1;
      chk("rst_ctl", ctl(), CTL_IDLE);
      chk("rst_sc", stall_count, 16'd0);
      tick();
      areset = 1'b1;
      tick(); tick(); tick();
      chk("idle3_ctl", ctl(), CTL_IDLE);
      chk("idle3_sc", stall_count, 16'd0);
      exp_sc = 16'd0;

      // load-use on rs
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
      id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      chk("lu_rs_ctl", ctl(), CTL_LU);
      tick();
      exp_sc = exp_sc + 16'd1;
      idle();
      #1;
      chk("lu_rs_sc", stall_count, exp_sc);
      chk("lu_rs_after", ctl(), CTL_IDLE);

      // load-use on rt only; rs matches but is not used
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd17;
      id_rs = 5'd17; id_uses_rs = 1'b0; id_rt = 5'd17; id_uses_rt = 1'b1;
      #1;
      chk("lu_rt_ctl", ctl(), CTL_LU);
      tick();
      exp_sc = exp_sc + 16'd1;
      idle();
      #1;
      chk("lu_rt_sc", stall_count, exp_sc);

      // rs matches but not used, rt differs: no stall
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
      id_rs = 5'd9; id_uses_rs = 1'b0; id_rt = 5'd3; id_uses_rt = 1'b1;
      #1;
      chk("lu_unused_ctl", ctl(), CTL_IDLE);
      tick();
      idle();

      // ex_rd = 0 never stalls
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
      id_rs = 5'd0; id_uses_rs = 1'b1;
      #1;
      chk("lu_r0_ctl", ctl(), CTL_IDLE);
      tick();
      idle();

      // load that does not write back: no stall
      ex_mem_read = 1'b1; ex_reg_write = 1'b0; ex_rd = 5'd4;
      id_rs = 5'd4; id_uses_rs = 1'b1;
      #1;
      chk("lu_nowr_ctl", ctl(), CTL_IDLE);
      tick();
      idle();
      #1;
      chk("nostall_sc", stall_count, exp_sc);

      // branch beats mdu_start and load-use
      branch_taken = 1'b1; mdu_start = 1'b1; mdu_div = 1'b1;
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
      id_rs = 5'd8; id_uses_rs = 1'b1;
      #1;
      chk("br_ctl", ctl(), CTL_BR);
      tick();
      idle();
      #1;
      chk("br_next_ctl", ctl(), CTL_IDLE);
      chk("br_sc", stall_count, exp_sc);

      // multiply: 4 stall cycles, done in the 4th
      mdu_start = 1'b1; mdu_div = 1'b0;
      #1;
      chk("mul_c1", ctl(), CTL_MDU);
      tick();
      idle();
      for (int c = 2; c <= 4; c++) begin
         chk($sformatf("mul_c%0d", c), ctl(), (c == 4) ? CTL_MDUD : CTL_MDU);
         tick();
      end
      exp_sc = exp_sc + 16'd4;
      chk("mul_c5", ctl(), CTL_IDLE);
      chk("mul_sc", stall_count, exp_sc);

      // divide aborted by reset in stall cycle 10
      mdu_start = 1'b1; mdu_div = 1'b1;
      #1;
      chk("div_c1", ctl(), CTL_MDU);
      tick();
      idle();
      for (int c = 2; c <= 10; c++) begin
         if (c == 10) chk("div_c10", ctl(), CTL_MDU);
         if (c < 10) tick();
      end
      areset = 1'b0;
      #1;
      chk("div_abort_ctl", ctl(), CTL_IDLE);
      chk("div_abort_sc", stall_count, 16'd0);
      #2 areset = 1'b1;
      tick();
      chk("div_resume_ctl", ctl(), CTL_IDLE);
      chk("div_resume_sc", stall_count, 16'd0);

      // back-to-back divides with mdu_start held: continuous stall
      mdu_start = 1'b1; mdu_div = 1'b1;
      for (int k = 1; k <= 65540; k++) begin
         if (k == 32) chk("b2b_c32_done", ctl(), CTL_MDUD);
         if (k == 33) chk("b2b_c33_restart", ctl(), CTL_MDU);
         tick();
         if (k == 65534) chk("sat_fffe", stall_count, 16'hFFFE);
         if (k == 65535) chk("sat_ffff", stall_count, 16'hFFFF);
      end
      chk("sat_hold", stall_count, 16'hFFFF);
      mdu_start = 1'b0;
      wait_cnt = 0;
      while (mdu_done !== 1'b1 && wait_cnt < 40) begin
         tick();
         wait_cnt++;
      end
      chk("sat_done_seen", {15'd0, mdu_done}, 16'd1);
      tick();
      chk("sat_end_ctl", ctl(), CTL_IDLE);
      chk("sat_end_sc", stall_count, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
